// File: rtl/vote_fifo_multi.sv
// vote_fifo_multi: majority-decodes redundantly encoded ballot bytes to single bits and assembles
// VOTE_BITS of them (LSB first) into a vote word. Vote words are buffered in a circular store
// (simple dual-port block RAM) and popped in order, one per request, with two cycles of latency.
// Optional feature: define VOTE_FIFO_TALLY_EN to add per-candidate running tallies of stored
// votes (tally_out) and a sticky flag for out-of-range vote words (invalid_vote_out).
module vote_fifo_multi #(
   parameter int unsigned NUM_CANDIDATES = 4,
   parameter int unsigned DEPTH          = 10000,
   parameter bit          TIE_VALUE      = 1'b0,
   localparam int unsigned VOTE_BITS     = (NUM_CANDIDATES > 1) ? $clog2(NUM_CANDIDATES) : 1,
   localparam int unsigned CNT_W         = $clog2(DEPTH + 1)
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   input  logic                 valid_in,
   input  logic                 sof_in,
   input  logic [7:0]           byte_in,
   input  logic                 request_in,
   output logic [VOTE_BITS-1:0] vote_out,
   output logic                 valid_vote_out,
   output logic [CNT_W-1:0]     count_out,
   output logic                 empty_out,
   output logic                 full_out,
   output logic                 overflow_out,
   output logic                 ambiguous_out
`ifdef VOTE_FIFO_TALLY_EN
   ,
   output logic [NUM_CANDIDATES*CNT_W-1:0] tally_out,
   output logic                            invalid_vote_out
`endif
);

   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned IDX_W = (VOTE_BITS > 1) ? $clog2(VOTE_BITS) : 1;

   // Byte decode
   logic [3:0] ones;
   logic       dec_bit;
   logic       tie_seen;

   // Assembler
   logic [IDX_W-1:0]     bit_idx_q, bit_idx_d, eff_idx;
   logic [VOTE_BITS-1:0] word_q, word_d, new_word;
   logic                 word_done;

   // Store control
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             store_full, store_empty;
   logic             wr_ok, rd_ok;

   // Store and read pipeline
   logic [VOTE_BITS-1:0] mem_q [DEPTH];
   logic [VOTE_BITS-1:0] ram_rdata_q;
   logic                 rd_pend_q;
   logic                 overflow_q, ambiguous_q;

   // Popcount the byte and majority-decode it; exactly four ones is a tie.
   always_comb begin
      ones = '0;
      for (int i = 0; i < 8; i++) begin
         ones = ones + 4'(byte_in[i]);
      end
      tie_seen = (ones == 4'd4);
      if (ones > 4'd4) begin
         dec_bit = 1'b1;
      end else if (ones < 4'd4) begin
         dec_bit = 1'b0;
      end else begin
         dec_bit = TIE_VALUE;
      end
   end

   // Place the decoded bit; sof restarts the word at bit 0 and discards any partial bits.
   always_comb begin
      eff_idx           = sof_in ? '0 : bit_idx_q;
      new_word          = sof_in ? '0 : word_q;
      new_word[eff_idx] = dec_bit;
      word_done         = valid_in && (eff_idx == IDX_W'(VOTE_BITS - 1));
      bit_idx_d         = bit_idx_q;
      word_d            = word_q;
      if (valid_in) begin
         if (word_done) begin
            bit_idx_d = '0;
            word_d    = '0;
         end else begin
            bit_idx_d = eff_idx + 1'b1;
            word_d    = new_word;
         end
      end
   end

   // Accept decisions use the occupancy at the start of the cycle; no write-through when full.
   always_comb begin
      store_full  = (count_q == CNT_W'(DEPTH));
      store_empty = (count_q == '0);
      wr_ok       = word_done && !store_full;
      rd_ok       = request_in && !store_empty;
   end

   // Assembler state.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         bit_idx_q <= '0;
         word_q    <= '0;
      end else begin
         bit_idx_q <= bit_idx_d;
         word_q    <= word_d;
      end
   end

   // Pointers, occupancy and sticky flags.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         ambiguous_q <= 1'b0;
      end else begin
         if (wr_ok) begin
            wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
         end
         if (rd_ok) begin
            rd_ptr_q <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
         end
         if (wr_ok && !rd_ok) begin
            count_q <= count_q + 1'b1;
         end else if (rd_ok && !wr_ok) begin
            count_q <= count_q - 1'b1;
         end
         if (word_done && store_full) begin
            overflow_q <= 1'b1;
         end
         if (valid_in && tie_seen) begin
            ambiguous_q <= 1'b1;
         end
      end
   end

   // Block RAM: one write port, one registered read port, no reset on the array.
   // A read never targets the slot being written because a full store refuses the write.
   always_ff @(posedge clk_in) begin
      if (wr_ok) begin
         mem_q[wr_ptr_q] <= new_word;
      end
      if (rd_ok) begin
         ram_rdata_q <= mem_q[rd_ptr_q];
      end
   end

   // Output register: RAM data lands one cycle after the read, so the vote appears at T+2.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         rd_pend_q      <= 1'b0;
         valid_vote_out <= 1'b0;
         vote_out       <= '0;
      end else begin
         rd_pend_q      <= rd_ok;
         valid_vote_out <= rd_pend_q;
         if (rd_pend_q) begin
            vote_out <= ram_rdata_q;
         end
      end
   end

   // Status outputs.
   always_comb begin
      count_out     = count_q;
      empty_out     = store_empty;
      full_out      = store_full;
      overflow_out  = overflow_q;
      ambiguous_out = ambiguous_q;
   end

`ifdef VOTE_FIFO_TALLY_EN
   logic [CNT_W-1:0] tally_q [NUM_CANDIDATES];
   logic             invalid_q;

   // Tally only words actually stored; out-of-range values raise the sticky invalid flag.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int c = 0; c < NUM_CANDIDATES; c++) begin
            tally_q[c] <= '0;
         end
         invalid_q <= 1'b0;
      end else if (wr_ok) begin
         if (32'(new_word) < NUM_CANDIDATES) begin
            tally_q[new_word] <= tally_q[new_word] + 1'b1;
         end else begin
            invalid_q <= 1'b1;
         end
      end
   end

   // Pack the per-candidate counts, candidate c at slice c.
   always_comb begin
      tally_out = '0;
      for (int c = 0; c < NUM_CANDIDATES; c++) begin
         tally_out[c*CNT_W +: CNT_W] = tally_q[c];
      end
      invalid_vote_out = invalid_q;
   end
`endif

endmodule

// File: tb/tb_vote_fifo_multi.sv
// Randomized self-checking bench for vote_fifo_multi (default build, NUM_CANDIDATES=4, DEPTH=4).
// A queue-based reference model tracks stored votes, the two-cycle read pipeline and stickies.
module tb_vote_fifo_multi;

   localparam int unsigned NC    = 4;
   localparam int unsigned DEPTH = 4;
   localparam bit          TIE   = 1'b0;
   localparam int unsigned VB    = 2;
   localparam int unsigned CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          valid = 1'b0;
   logic          sof = 1'b0;
   logic [7:0]    byte_v = '0;
   logic          request = 1'b0;
   logic [VB-1:0] vote_out;
   logic          valid_vote_out;
   logic [CW-1:0] count_out;
   logic          empty_out, full_out, overflow_out, ambiguous_out;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   int q[$];
   int k_m = 0;
   int word_m = 0;
   bit s1_v = 0;
   int s1_val = 0;
   bit out_v = 0;
   int out_val = 0;
   bit ovf_m = 0;
   bit amb_m = 0;

   vote_fifo_multi #(
      .NUM_CANDIDATES(NC),
      .DEPTH         (DEPTH),
      .TIE_VALUE     (TIE)
   ) dut (
      .clk_in        (clk),
      .rst_n_in      (rst_n),
      .valid_in      (valid),
      .sof_in        (sof),
      .byte_in       (byte_v),
      .request_in    (request),
      .vote_out      (vote_out),
      .valid_vote_out(valid_vote_out),
      .count_out     (count_out),
      .empty_out     (empty_out),
      .full_out      (full_out),
      .overflow_out  (overflow_out),
      .ambiguous_out (ambiguous_out)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      k_m = 0; word_m = 0;
      s1_v = 0; s1_val = 0;
      out_v = 0; out_val = 0;
      ovf_m = 0; amb_m = 0;
   endtask

   // One clock edge of the reference behaviour, using the inputs held across the edge.
   task automatic model_edge();
      int  pre;
      int  ones;
      int  b;
      bit  rd;
      bit  wr;
      int  w;
      pre = q.size();
      rd  = request && (pre > 0);
      wr  = 0;
      w   = 0;
      out_v = s1_v;
      if (s1_v) out_val = s1_val;
      s1_v = rd;
      if (rd) s1_val = q[0];
      if (valid) begin
         ones = $countones(byte_v);
         b = (ones > 4) ? 1 : ((ones < 4) ? 0 : int'(TIE));
         if (ones == 4) amb_m = 1;
         if (sof) begin
            k_m = 0;
            word_m = 0;
         end
         word_m += b << k_m;
         k_m++;
         if (k_m == VB) begin
            wr = 1;
            w = word_m;
            k_m = 0;
            word_m = 0;
         end
      end
      if (rd) void'(q.pop_front());
      if (wr) begin
         if (pre < DEPTH) q.push_back(w);
         else ovf_m = 1;
      end
   endtask

   task automatic check_all();
      check_eq("count", 32'(count_out), q.size());
      check_eq("empty", 32'(empty_out), (q.size() == 0) ? 1 : 0);
      check_eq("full", 32'(full_out), (q.size() == DEPTH) ? 1 : 0);
      check_eq("overflow", 32'(overflow_out), ovf_m);
      check_eq("ambiguous", 32'(ambiguous_out), amb_m);
      check_eq("valid_vote", 32'(valid_vote_out), out_v);
      check_eq("vote", 32'(vote_out), out_val);
   endtask

   task automatic cycle(input bit v, input bit s, input logic [7:0] b, input bit r);
      valid = v; sof = s; byte_v = b; request = r;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 8'h00, 0);
   endtask

   // Asynchronous reset asserted away from the clock edge, released at a falling edge.
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      valid = 0; sof = 0; request = 0;
      model_reset();
      #1;
      check_all();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic logic [7:0] rand_byte();
      logic [7:0] pat;
      pat = 8'h0F;
      if ($urandom_range(0, 3) == 0) return 8'((pat << $urandom_range(0, 4)) | (pat >> 4));
      return 8'($urandom);
   endfunction

   initial begin
      model_reset();
      #12;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;

      // Basic vote: FF (bit0=1), 00 (bit1=0) -> 2'b01
      cycle(1, 1, 8'hFF, 0);
      cycle(1, 0, 8'h00, 0);
      check_eq("t1_count_before", 32'(count_out), 1);
      cycle(0, 0, 8'h00, 1);
      check_eq("t1_count_after", 32'(count_out), 0);
      check_eq("t1_not_yet_valid", 32'(valid_vote_out), 0);
      cycle(0, 0, 8'h00, 0);
      check_eq("t1_valid", 32'(valid_vote_out), 1);
      check_eq("t1_vote", 32'(vote_out), 1);
      cycle(0, 0, 8'h00, 0);
      check_eq("t1_hold", 32'(vote_out), 1);

      // Ties decode to TIE_VALUE and set ambiguous
      cycle(1, 1, 8'h0F, 0);
      cycle(1, 0, 8'hF0, 0);
      check_eq("t2_ambiguous", 32'(ambiguous_out), 1);
      cycle(0, 0, 8'h00, 1);
      idle(1);
      check_eq("t2_vote", 32'(vote_out), 0);

      // Fill past capacity, then drain in order
      do_reset();
      for (int i = 0; i < 5; i++) begin
         cycle(1, 1, (i % 2) ? 8'hFF : 8'h01, 0);
         cycle(1, 0, (i / 2 % 2) ? 8'hFE : 8'h10, 0);
         if (i == 3) check_eq("t3_full", 32'(full_out), 1);
      end
      check_eq("t3_overflow", 32'(overflow_out), 1);
      for (int i = 0; i < 4; i++) cycle(0, 0, 8'h00, 1);
      cycle(0, 0, 8'h00, 1);
      idle(2);
      check_eq("t3_empty", 32'(empty_out), 1);

      // Stray byte then sof resync: one vote of 2'b11
      cycle(1, 0, 8'h00, 0);
      cycle(1, 1, 8'hFF, 0);
      cycle(1, 0, 8'hFF, 0);
      check_eq("t4_count", 32'(count_out), 1);
      cycle(0, 0, 8'h00, 1);
      idle(1);
      check_eq("t4_vote", 32'(vote_out), 3);

      // Interleaved push/pop across the wrap, including simultaneous push and pop at count 1
      for (int i = 0; i < 7; i++) begin
         cycle(1, 1, 8'(i * 37), 0);
         cycle(1, 0, 8'(i * 91 + 3), (i > 0) ? 1'b1 : 1'b0);
      end
      idle(3);

      // Reset mid-assembly with a read in flight
      cycle(1, 0, 8'hFF, 1);
      do_reset();
      idle(3);
      check_eq("t6_no_valid", 32'(valid_vote_out), 0);
      cycle(1, 0, 8'hFF, 0);
      cycle(1, 0, 8'h00, 0);
      cycle(0, 0, 8'h00, 1);
      idle(1);
      check_eq("t6_vote", 32'(vote_out), 1);

      // Randomized phases with varying read pressure
      for (int ph = 0; ph < 3; ph++) begin
         for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 1) == 1), ($urandom_range(0, 9) == 0), rand_byte(),
                  ($urandom_range(0, 9) < (ph * 3 + 2)));
         end
         if (ph == 1) do_reset();
      end
      idle(3);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
